// File: rtl/imc_pkg.sv
// Shared definitions for the instruction memory controller: phase encoding and opcode constants.
package imc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } imc_state_e;

    // Returned in place of memory data for fetches past the loaded program
    localparam logic [7:0] OP_NOP = 8'd34;

endpackage

// File: rtl/imc_fetch_pipe.sv
// One-stage register tracking which fetch requests return data next cycle and whether they were out of bounds.
module imc_fetch_pipe (
    input  logic clk,
    input  logic rst,
    input  logic accept,
    input  logic oob_in,
    output logic valid_o,
    output logic oob_o
);

    logic valid_q, valid_d;
    logic oob_q, oob_d;

    always_comb begin
        valid_d = accept;
        oob_d   = accept & oob_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            oob_q   <= oob_d;
        end
    end

    assign valid_o = valid_q;
    assign oob_o   = oob_q;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory sequencer: program download, core fetch with bounds guard, halt.
// Define IMC_OVF_CHK_EN to stop writes once the memory is full and raise the sticky ld_err flag.
module instr_mem_ctrl
    import imc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic                    ld_valid,
    input  logic [2*DATA_WIDTH-1:0] ld_data,
    input  logic                    ld_last,
    output logic                    ld_ready,
    input  logic                    run_start,
    input  logic                    core_halt,
    input  logic                    fetch_req,
    input  logic [ADDR_WIDTH-1:0]   fetch_addr,
    output logic                    fetch_ready,
    output logic                    fetch_valid,
    output logic [DATA_WIDTH-1:0]   fetch_instr,
    output logic                    fetch_oob,
    output logic [ADDR_WIDTH:0]     prog_len,
    output logic [1:0]              state_o,
    output logic                    ld_err,
    output logic                    mem_we,
    output logic [2*DATA_WIDTH-1:0] mem_w_instr,
    output logic [ADDR_WIDTH-1:0]   mem_w_addr,
    output logic [ADDR_WIDTH-1:0]   mem_r_addr,
    input  logic [DATA_WIDTH-1:0]   mem_r_instr
);

    localparam logic [ADDR_WIDTH:0]   CAPACITY      = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   LEN_STEP      = (ADDR_WIDTH + 1)'(2);
    localparam logic [ADDR_WIDTH:0]   LAST_BEAT_LEN = CAPACITY - LEN_STEP;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP     = ADDR_WIDTH'(2);

    imc_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   prog_len_q, prog_len_d;

    logic                  restart;
    logic                  beat;
    logic                  drop;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [ADDR_WIDTH:0]   len_base;
    logic                  accept;
    logic                  req_oob;
    logic                  pipe_oob;

    // A load_start seen during LOAD rebases the same-cycle beat to address 0
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        prog_len_d = prog_len_q;
        restart    = 1'b0;
        beat       = 1'b0;
        drop       = 1'b0;
        write_en   = 1'b0;
        w_base     = wptr_q;
        len_base   = prog_len_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    restart = 1'b1;
                end else if (run_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                restart = load_start;
                beat    = ld_valid;
                if (ld_valid && ld_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (core_halt) begin
                    state_d = ST_HALT;
                end
            end
        endcase

        if (restart) begin
            w_base     = '0;
            len_base   = '0;
            wptr_d     = '0;
            prog_len_d = '0;
        end

        if (beat) begin
`ifdef IMC_OVF_CHK_EN
            drop = (len_base == CAPACITY);
`endif
            if (!drop) begin
                write_en   = !rst;
                wptr_d     = w_base + ADDR_STEP;
                prog_len_d = (len_base >= LAST_BEAT_LEN) ? CAPACITY : len_base + LEN_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            prog_len_q <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            prog_len_q <= prog_len_d;
        end
    end

`ifdef IMC_OVF_CHK_EN
    logic ld_err_q, ld_err_d;

    always_comb begin
        ld_err_d = ld_err_q;
        if (restart) begin
            ld_err_d = 1'b0;
        end
        if (drop) begin
            ld_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_err_q <= 1'b0;
        end else begin
            ld_err_q <= ld_err_d;
        end
    end

    assign ld_err = ld_err_q;
`else
    assign ld_err = 1'b0;
`endif

    assign ld_ready    = (state_q == ST_LOAD);
    assign mem_we      = write_en;
    assign mem_w_addr  = write_en ? w_base : '0;
    assign mem_w_instr = write_en ? ld_data : '0;

    // The memory registers its read, so the address goes out combinationally
    assign fetch_ready = (state_q == ST_RUN) && !mem_we;
    assign accept      = fetch_req && fetch_ready;
    assign req_oob     = ({1'b0, fetch_addr} >= prog_len_q);
    assign mem_r_addr  = (state_q == ST_RUN) ? fetch_addr : '0;

    imc_fetch_pipe u_fetch_pipe (
        .clk     (clk),
        .rst     (rst),
        .accept  (accept),
        .oob_in  (req_oob),
        .valid_o (fetch_valid),
        .oob_o   (pipe_oob)
    );

    assign fetch_oob   = pipe_oob;
    assign fetch_instr = !fetch_valid ? '0 :
                         pipe_oob     ? DATA_WIDTH'(OP_NOP) : mem_r_instr;
    assign prog_len    = prog_len_q;
    assign state_o     = state_q;

endmodule
